// File: rtl/output_port_scheduler.sv
// Purpose : four-input round-robin scheduler. It pops one single-flit packet per grant
//           into a one-entry output register and drains that register with valid/ready.
// Latency : req seen with space in cycle n -> gnt in cycle n (Mealy) -> out_valid in cycle n+1.
// Backpres: the register accepts a new packet only when it is empty or draining this cycle.
//           While it is stalled, gnt stays 0 and out_data holds.
// Ports   : clk, rst_n (synchronous, active-HIGH despite the name), en (arbitration enable),
//           req[3:0] / data0..data3 (heads of the input buffers), gnt[3:0] (one-hot pop strobe),
//           out_valid / out_data / out_ready (downstream handshake), pkt_cnt (packets handed off).
module output_port_scheduler #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic [DATA_W-1:0] data3,
   output logic [3:0]        gnt,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  pkt_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        ptr;
   logic [1:0]        winner;
   logic [1:0]        idx;
   logic              found;
   logic              space;
   logic              xfer;
   logic              grant;
   logic [DATA_W-1:0] win_data;

   assign out_valid = (state == FULL);
   assign space     = !out_valid || out_ready;
   assign xfer      = out_valid && out_ready;
   // rst_n is active-high: no grant may pop a buffer while reset is asserted.
   assign grant     = en && space && (|req) && !rst_n;
   assign gnt       = grant ? (4'b0001 << winner) : 4'b0000;

   // Rotating priority search. It starts at ptr and takes the first requester
   // in ptr, ptr+1, ... order, so idle inputs cost no cycle. The 2-bit index
   // wraps modulo 4 on its own.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      win_data = data0;
      case (winner)
         2'd0:    win_data = data0;
         2'd1:    win_data = data1;
         2'd2:    win_data = data2;
         default: win_data = data3;
      endcase
   end

   // EMPTY/FULL tracks whether the output register is occupied.
   // A grant always fills it. A transfer without a grant empties it.
   // A transfer together with a grant keeps it FULL: back-to-back, one packet per cycle.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (grant) state_next = FULL;
         FULL:    if (xfer && !grant) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         // A packet still held in the register is dropped without being counted.
         state    <= EMPTY;
         ptr      <= 2'd0;
         out_data <= '0;
         pkt_cnt  <= '0;
      end else begin
         state <= state_next;
         // out_data changes only on a load. It keeps its last value after draining.
         if (grant) begin
            out_data <= win_data;
            ptr      <= winner + 2'd1;
         end
         if (xfer) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Purpose : self-checking bench for output_port_scheduler. It drives a table of
//           fixed vectors, then hand-written corner-case sequences, then
//           randomized traffic compared against a behavioural model.
// Ports   : none; it instantiates the DUT and drives its clock.
module tb_output_port_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  req;
   logic [63:0] d [4];
   logic [3:0]  gnt;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready;
   logic [15:0] pkt_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   output_port_scheduler #(.DATA_W(64), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .data0     (d[0]),
      .data1     (d[1]),
      .data2     (d[2]),
      .data3     (d[3]),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .pkt_cnt   (pkt_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Fixed head-of-buffer values used by the directed part. Index 4 stands for all-zero data.
   function automatic logic [63:0] dconst(input int i);
      if (i >= 4) return 64'h0;
      return 64'h1111_1111_1111_1111 * 64'(i + 1);
   endfunction

   // Applies one cycle of inputs at negedge, then checks 1 ns later.
   // The checks see the Mealy gnt of this cycle and the registered state
   // built up by the earlier posedges.
   task automatic cyc(input logic r, input logic e, input logic [3:0] q, input logic rd,
                      input logic [3:0] eg, input logic chk, input logic ev,
                      input int di, input int ec, input string tag);
      @(negedge clk);
      rst_n = r; en = e; req = q; out_ready = rd;
      #1;
      check({tag, " gnt"}, 64'(gnt), 64'(eg));
      if (chk) begin
         check({tag, " out_valid"}, 64'(out_valid), 64'(ev));
         check({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'(ec));
         if (di >= 0) check({tag, " out_data"}, out_data, dconst(di));
      end
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] req;
      logic       rdy;
      logic [3:0] gnt;
      logic       chk;
      logic       vld;
      int         didx;
      int         cnt;
   } vec_t;

   vec_t tv [15];

   // Behavioural model state for the random phase.
   int          m_ptr;
   bit          m_vld;
   logic [63:0] m_dat;
   int          m_cnt;
   bit [3:0]    g_last;

   initial begin
      rst_n = 1'b1; en = 1'b1; req = 4'hF; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = dconst(i);

      //         rst en  req   rdy  gnt  chk vld didx cnt
      tv[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, -1, 0};  // reset, state not checked yet
      tv[1]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0,  4, 0};  // reset held
      tv[2]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0, -1, 0};  // full load, round robin
      tv[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1,  0, 0};
      tv[4]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1,  1, 1};
      tv[5]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1,  2, 2};
      tv[6]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1,  3, 3};
      tv[7]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1,  0, 4};
      tv[8]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1,  1, 5};
      tv[9]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1,  2, 6};
      tv[10] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h2, 1'b1, 1'b1,  3, 7};  // sparse: idle inputs skipped
      tv[11] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h8, 1'b1, 1'b1,  1, 8};
      tv[12] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h2, 1'b1, 1'b1,  3, 9};
      tv[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1,  1, 10}; // last packet drains
      tv[14] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0,  1, 11}; // empty, data kept

      for (int v = 0; v < 15; v++)
         cyc(tv[v].rst, tv[v].en, tv[v].req, tv[v].rdy, tv[v].gnt,
             tv[v].chk, tv[v].vld, tv[v].didx, tv[v].cnt, $sformatf("vec%0d", v));

      // Stall: ptr=2 here. Load input 2, hold it for 5 cycles, then a transfer and a grant in one cycle.
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 1'b0, -1, 11, "stall_load");
      for (int s = 0; s < 5; s++)
         cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1, 2, 11, $sformatf("stall_hold%0d", s));
      cyc(1'b0, 1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 2, 11, "stall_release");

      // en=0: the held packet drains and no new grant is issued.
      cyc(1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1, 3, 12, "en0_drain");
      cyc(1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0, 3, 13, "en0_empty");

      // Reset during a stall: the held packet is dropped and ptr returns to 0 (it was 1).
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0, 3, 13, "pre_rst_load");
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1, 0, 13, "pre_rst_stall");
      cyc(1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1, 0, 13, "rst_mid_stall");
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0, 4, 0,  "post_rst_first");

      // Random traffic against the model. Start from a clean reset.
      @(negedge clk);
      rst_n = 1'b1; req = 4'h0;
      m_ptr = 0; m_vld = 0; m_dat = 64'h0; m_cnt = 0; g_last = 4'h0;
      for (int c = 0; c < 1500; c++) begin
         int          win;
         bit          r;
         bit          e;
         bit          rd;
         logic [3:0]  eg;
         @(negedge clk);
         // Requesters keep data stable while they request and have not been popped.
         for (int i = 0; i < 4; i++) begin
            if (req[i] && !g_last[i]) begin
               if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
            end else begin
               d[i]   = {$urandom, $urandom};
               req[i] = ($urandom_range(0, 2) != 0);
            end
         end
         r  = ($urandom_range(0, 63) == 0);
         e  = ($urandom_range(0, 7) != 0);
         rd = ($urandom_range(0, 3) != 0);
         rst_n = r; en = e; out_ready = rd;
         #1;
         win = -1;
         if (!r && e && (!m_vld || rd))
            for (int k = 0; k < 4; k++)
               if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
         eg = (win < 0) ? 4'h0 : 4'(1 << win);
         check("rand gnt", 64'(gnt), 64'(eg));
         check("rand out_valid", 64'(out_valid), 64'(m_vld));
         check("rand out_data", out_data, m_dat);
         check("rand pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
         g_last = eg;
         if (r) begin
            m_vld = 0; m_dat = 64'h0; m_ptr = 0; m_cnt = 0;
         end else begin
            if (m_vld && rd) begin
               m_cnt = (m_cnt + 1) % 65536;
               m_vld = 0;
            end
            if (win >= 0) begin
               m_dat = d[win];
               m_vld = 1;
               m_ptr = (win + 1) % 4;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
